// File: rtl/cms_trace_receiver.sv
// AXI-Stream sink for the CMS trace stream: FWFT FIFO of {tlast, pc, instr} with tlast frame checking.
// Define CMS_RX_RESYNC_EN to drop beats after a framing error until the next tlast.
module cms_trace_receiver #(
  parameter int XLEN           = 64,
  parameter int AXI_DATA_WIDTH = XLEN + 32,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                      S_AXIS_tlast,
  input  logic [31:0]               tlast_interval,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_instr,
  output logic                      out_last,
  output logic [31:0]               beat_count,
  output logic                      frame_err,
  input  logic                      err_clear
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = XLEN + 33;

  typedef enum logic {RUN, RESYNC} state_t;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [AW:0]        count, count_next;
  logic [31:0]        fcnt, fcnt_next, fcnt_inc;
  state_t             state, state_next;

  logic               accept, pop, push;
  logic               check_en, early, missing, err_set, frame_done;
  logic [ENTRY_W-1:0] new_entry, head_next;

  assign accept    = S_AXIS_tvalid & S_AXIS_tready;
  assign pop       = out_valid & out_ready;
  assign push      = accept & (state == RUN);
  assign new_entry = {S_AXIS_tlast, S_AXIS_tdata[AXI_DATA_WIDTH-1:32], S_AXIS_tdata[31:0]};

  always_comb begin
    wr_ptr_next = push ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_next = pop  ? rd_ptr + AW'(1) : rd_ptr;
    count_next  = count;
    if (push && !pop)      count_next = count + (AW+1)'(1);
    else if (!push && pop) count_next = count - (AW+1)'(1);
  end

  // Head after this edge: the incoming beat when it lands exactly at the new read pointer.
  assign head_next = (push && (wr_ptr == rd_ptr_next)) ? new_entry : mem[rd_ptr_next];

  assign fcnt_inc   = fcnt + 32'd1;
  assign check_en   = accept && (state == RUN) && (tlast_interval != 32'd0);
  assign frame_done = fcnt_inc == tlast_interval;
  assign early      = check_en &&  S_AXIS_tlast && (fcnt_inc < tlast_interval);
  assign missing    = check_en && !S_AXIS_tlast && frame_done;
  assign err_set    = early | missing;

  always_comb begin
    fcnt_next  = fcnt;
    state_next = state;
    if (state == RESYNC) begin
      if (accept && S_AXIS_tlast) begin
        fcnt_next  = 32'd0;
        state_next = RUN;
      end
    end else if (tlast_interval == 32'd0) begin
      fcnt_next = 32'd0;
    end else if (accept) begin
      if (err_set || (S_AXIS_tlast && frame_done)) begin
        fcnt_next = 32'd0;
`ifdef CMS_RX_RESYNC_EN
        if (err_set) state_next = RESYNC;
`endif
      end else begin
        fcnt_next = fcnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      S_AXIS_tready <= 1'b0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_instr     <= '0;
      out_last      <= 1'b0;
      beat_count    <= '0;
      frame_err     <= 1'b0;
      fcnt          <= '0;
      state         <= RUN;
    end else begin
      wr_ptr        <= wr_ptr_next;
      rd_ptr        <= rd_ptr_next;
      count         <= count_next;
      S_AXIS_tready <= count_next != (AW+1)'(FIFO_DEPTH);
      out_valid     <= count_next != '0;
      if (count_next != '0) {out_last, out_pc, out_instr} <= head_next;
      if (accept) beat_count <= beat_count + 32'd1;
      if (err_set)        frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      fcnt          <= fcnt_next;
      state         <= state_next;
    end
  end

endmodule

// File: tb/tb_cms_trace_receiver.sv
// Directed self-checking bench for cms_trace_receiver (works with or without CMS_RX_RESYNC_EN).
module tb_cms_trace_receiver;

  localparam int XLEN  = 64;
  localparam int DW    = XLEN + 32;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            tvalid = 1'b0;
  logic            tready;
  logic [DW-1:0]   tdata = '0;
  logic            tlast = 1'b0;
  logic [31:0]     tlast_interval = 32'd0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_last;
  logic [31:0]     beat_count;
  logic            frame_err;
  logic            err_clear = 1'b0;

  int errors = 0;
  int checks = 0;

  cms_trace_receiver #(.XLEN(XLEN), .AXI_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready), .S_AXIS_tdata(tdata), .S_AXIS_tlast(tlast),
    .tlast_interval(tlast_interval),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_last(out_last), .beat_count(beat_count), .frame_err(frame_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // Presents one beat, waits (bounded) for tready, and returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [63:0] pc, input logic [31:0] instr, input logic last, input logic clr);
    int waited;
    waited = 0;
    tvalid = 1'b1; tdata = {pc, instr}; tlast = last; err_clear = clr;
    while (!tready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: tready=%b required 1 for pc=%h", tready, pc);
    end else begin
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0; err_clear = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready_low: got %b required 0", tready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready_before_edge: got %b required 0", tready); end
    @(posedge clk); #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL rst_tready_after: got %b required 1", tready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b required 0", out_valid); end
    checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL rst_beat_count: got %0d required 0", beat_count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b required 0", frame_err); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL rst_out_pc: got %h required 0", out_pc); end
    $display("test_reset done: tready=%b out_valid=%b", tready, out_valid);
  endtask

  task automatic test_stream();
    logic [63:0] pc;
    logic        last;
    tlast_interval = 32'd4;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pc   = 64'h8 + 64'(4 * i);
      last = (i == 3) || (i == 7);
      send_beat(pc, 32'h0000006f, last, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b required 1", i, out_valid); end
      checks++; if (out_pc !== pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h required %h", i, out_pc, pc); end
      checks++; if (out_instr !== 32'h0000006f) begin errors++; $display("FAIL stream_instr[%0d]: got %h required 0000006f", i, out_instr); end
      checks++; if (out_last !== last) begin errors++; $display("FAIL stream_last[%0d]: got %b required %b", i, out_last, last); end
      $display("stream beat %0d: pc=%h last=%b", i, out_pc, out_last);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b required 0", out_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL stream_frame_err: got %b required 0", frame_err); end
    checks++; if (beat_count !== 32'd8) begin errors++; $display("FAIL stream_beat_count: got %0d required 8", beat_count); end
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    out_ready = 1'b0;
    tlast_interval = 32'd0;
    tvalid = 1'b1; tlast = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tdata = {64'h1000 + 64'(accepted), 32'h00000013};
      if (tready) accepted++;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    $display("backpressure: accepted=%0d tready=%b", accepted, tready);
    checks++; if (accepted != DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d required %0d", accepted, DEPTH); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL bp_tready_full: got %b required 0", tready); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %b required 1", i, out_valid); end
      checks++; if (out_pc !== 64'h1000 + 64'(i)) begin errors++; $display("FAIL bp_drain_pc[%0d]: got %h required %h", i, out_pc, 64'h1000 + 64'(i)); end
      @(posedge clk); #1;
      if (i == 0) begin
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL bp_tready_return: got %b required 1", tready); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b required 0", out_valid); end
    checks++; if (beat_count !== 32'd16) begin errors++; $display("FAIL bp_beat_count: got %0d required 16", beat_count); end
  endtask

  task automatic test_frame_err();
    tlast_interval = 32'd4;
    out_ready = 1'b1;
    send_beat(64'h2001, 32'h1, 1'b0, 1'b0);
    send_beat(64'h2002, 32'h1, 1'b1, 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_early: got %b required 1", frame_err); end
    send_beat(64'h2003, 32'h1, 1'b0, 1'b1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_clear: got %b required 0", frame_err); end
    send_beat(64'h2004, 32'h1, 1'b0, 1'b0);
    send_beat(64'h2005, 32'h1, 1'b0, 1'b0);
    send_beat(64'h2006, 32'h1, 1'b1, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_restart: got %b required 0", frame_err); end
    send_beat(64'h2007, 32'h1, 1'b0, 1'b0);
    send_beat(64'h2008, 32'h1, 1'b0, 1'b0);
    send_beat(64'h2009, 32'h1, 1'b0, 1'b0);
    send_beat(64'h200a, 32'h1, 1'b0, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_set_wins: got %b required 1", frame_err); end
    tlast_interval = 32'd0;
    send_beat(64'h200b, 32'h1, 1'b1, 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_sticky: got %b required 1", frame_err); end
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_idle_clear: got %b required 0", frame_err); end
    @(posedge clk); #1;
    checks++; if (beat_count !== 32'd27) begin errors++; $display("FAIL fe_beat_count: got %0d required 27", beat_count); end
    $display("test_frame_err done: frame_err=%b beat_count=%0d", frame_err, beat_count);
  endtask

  task automatic test_resync();
    int exp_ids[$];
`ifdef CMS_RX_RESYNC_EN
    exp_ids = '{1, 2, 6};
`else
    exp_ids = '{1, 2, 3, 4, 5, 6};
`endif
    tlast_interval = 32'd4;
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++)
      send_beat(64'h3000 + 64'(k), 32'h2, (k == 2) || (k == 5), 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL rs_frame_err: got %b required 1", frame_err); end
    checks++; if (beat_count !== 32'd33) begin errors++; $display("FAIL rs_beat_count: got %0d required 33", beat_count); end
    out_ready = 1'b1;
    foreach (exp_ids[i]) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rs_valid[%0d]: got %b required 1", i, out_valid); end
      checks++; if (out_pc !== 64'h3000 + 64'(exp_ids[i])) begin errors++; $display("FAIL rs_pc[%0d]: got %h required %h", i, out_pc, 64'h3000 + 64'(exp_ids[i])); end
      $display("resync item %0d: pc=%h", i, out_pc);
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_empty: got %b required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    tlast_interval = 32'd0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_beat(64'h4100 + 64'(k), 32'h3, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: got %b required 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b required 0", out_valid); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL mid_async_tready: got %b required 0", tready); end
    checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL mid_beat_count: got %0d required 0", beat_count); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL mid_tready_after: got %b required 1", tready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_empty_after: got %b required 0", out_valid); end
    send_beat(64'h4000, 32'h4, 1'b0, 1'b0);
    checks++; if (out_pc !== 64'h4000) begin errors++; $display("FAIL mid_flushed_head: got %h required 0000000000004000", out_pc); end
    $display("test_reset_mid done: head pc=%h", out_pc);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_frame_err();
    test_resync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cms_trace_receiver.md
Name: cms_trace_receiver

Overview:
- AXI-Stream slave that sits at the far end of the continuous monitoring system's trace stream (the FIFO/DMA-side consumer).
- Accepts packed {pc, instr} beats and buffers them in a small FIFO.
- Presents the unpacked items to a local consumer over a valid/ready interface.
- Checks tlast framing against the configured interval and exposes a beat counter plus a sticky framing-error flag.

Parameters:
- XLEN, 64, width of the pc field.
- AXI_DATA_WIDTH, XLEN+32, width of S_AXIS_tdata.
- FIFO_DEPTH, 8, number of buffered beats; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- S_AXIS_tvalid  in  1  beat valid from the monitoring system.
- S_AXIS_tready  out  1  receiver can accept a beat.
- S_AXIS_tdata  in  AXI_DATA_WIDTH  [AXI_DATA_WIDTH-1:32]=pc, [31:0]=instr.
- S_AXIS_tlast  in  1  end-of-frame marker.
- tlast_interval  in  32  expected beats per frame; 0 disables the framing check.
- out_valid  out  1  item available.
- out_ready  in  1  consumer accepts the item.
- out_pc  out  XLEN  pc of the head item.
- out_instr  out  32  instr of the head item.
- out_last  out  1  tlast of the head item.
- beat_count  out  32  total beats accepted; wraps modulo 2^32.
- frame_err  out  1  sticky framing error.
- err_clear  in  1  clears frame_err.

Behaviour:
- Clock and reset: single clock domain (clk); rst_n is asynchronous, active-low.
- Reset values: S_AXIS_tready=0 while rst_n=0, and 1 from the first clk edge after release (FIFO empty). out_valid=0; out_pc, out_instr, out_last=0; beat_count=0; frame_err=0; frame beat counter=0; FSM=RUN.
- Reset mid-operation: flushes the FIFO; any buffered items are lost.
- Accept and pop:
  - Accept when S_AXIS_tvalid && S_AXIS_tready.
  - Pop when out_valid && out_ready.
- FIFO storage: each entry stores {tlast, pc, instr}. Read side is first-word-fall-through: out_* always reflect the head entry, and out_valid = !empty.
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle). There is no combinational path from S_AXIS to out_*.
- Backpressure:
  - S_AXIS_tready = !full, registered from the FIFO occupancy.
  - When full, tready=0 even if a pop occurs in the same cycle (no bypass).
  - Push and pop in the same cycle while neither empty nor full: occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - tready must not depend combinationally on tvalid.
- beat_count: increments on every accepted beat, including beats dropped in RESYNC.
- Frame checker (active when tlast_interval != 0):
  - fcnt counts accepted beats within the current frame, 1..tlast_interval.
  - Early tlast (tlast=1, fcnt+1 < tlast_interval): set frame_err; fcnt becomes 0.
  - Missing tlast (tlast=0, fcnt+1 == tlast_interval): set frame_err; fcnt becomes 0.
  - Correct tlast (tlast=1, fcnt+1 == tlast_interval): fcnt becomes 0.
  - Otherwise: fcnt increments.
  - tlast_interval is sampled on every beat; changing it mid-frame takes effect on the next beat.
- When tlast_interval == 0: fcnt is held at 0 and frame_err is never set.
- frame_err: sticky. err_clear clears it. If err_clear and a new error occur in the same cycle, set wins.
- FSM states: RUN, RESYNC. RESYNC is reachable only with the optional feature (see below). In RUN, accepted beats are pushed into the FIFO.

Optional Feature:
- Macro: CMS_RX_RESYNC_EN.
- Defined:
  - Any framing error moves the FSM RUN -> RESYNC. The offending beat itself is still pushed.
  - In RESYNC, accepted beats are consumed with tready per FIFO rules but not pushed; beat_count still increments.
  - An accepted beat with tlast=1 in RESYNC is dropped, resets fcnt to 0, and returns the FSM to RUN; the next beat starts a fresh frame.
  - Framing checks are suspended while in RESYNC.
- Undefined: the FSM stays in RUN permanently and all beats are pushed regardless of errors.

Test Plan:
- Reset then idle -> tready=1 one edge after release; out_valid=0; beat_count=0; frame_err=0.
- tlast_interval=4; 8 beats pc=0x8..0x24, instr=0x0000006f, tlast on beats 4 and 8; out_ready=1 -> items emerge in order with 1-cycle latency; out_last on the 4th and 8th; frame_err=0; beat_count=8.
- out_ready=0 with tvalid held high -> exactly FIFO_DEPTH=8 beats accepted, then tready=0. Raise out_ready -> tready returns to 1 on the next edge; no beats lost or duplicated.
- tlast_interval=4, tlast on beat 2 -> frame_err=1; fcnt restarts. Assert err_clear on a clean beat -> frame_err=0. Assert err_clear on the same cycle as a missing-tlast beat -> frame_err stays 1.
- With CMS_RX_RESYNC_EN: error on beat 2, then beats 3,4,5 with tlast on 5 -> beats 3-5 are not output; beat 6 is output; beat_count counts all beats.
- Assert rst_n low while the FIFO holds 5 items -> out_valid=0 and tready=0 immediately (asynchronous); after release tready=1 with an empty FIFO.
